// File: rtl/lfsr_decrypt_engine.sv
// LFSR stream decryptor: trains NTAPS candidate tap patterns on a known preamble,
// selects the lowest-index survivor, then streams the plaintext back to memory.
module lfsr_decrypt_engine #(
  parameter int unsigned        W            = 6,
  parameter int unsigned        NTAPS        = 6,
  parameter logic [NTAPS*W-1:0] TAPS         = {6'h39, 6'h36, 6'h33, 6'h30, 6'h2D, 6'h21},
  parameter logic [7:0]         PRE_CHAR     = 8'h5F,
  parameter int unsigned        PREAMBLE_LEN = 7,
  parameter int unsigned        MSG_LEN      = 64,
  parameter int unsigned        AW           = 8,
  parameter int unsigned        SRC_BASE     = 64,
  parameter int unsigned        DST_BASE     = 0,
  localparam int unsigned       SW           = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
  input  logic          clk,
  input  logic          init_n,
  input  logic          start,
  input  logic          strip,
  output logic [AW-1:0] raddr,
  input  logic [7:0]    rdata,
  output logic [AW-1:0] waddr,
  output logic [7:0]    wdata,
  output logic          wr_en,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [SW-1:0] tap_sel
);

  localparam int unsigned   CW           = $clog2(MSG_LEN + 1);
  localparam logic [W-1:0]  PRE_MASK     = PRE_CHAR[W-1:0];
  localparam logic [AW-1:0] SRC_A        = AW'(SRC_BASE);
  localparam logic [AW-1:0] DST_A        = AW'(DST_BASE);
  localparam logic [CW-1:0] PRE_LAST     = CW'(PREAMBLE_LEN - 1);
  localparam logic [CW-1:0] PRE_NEARLAST = CW'(PREAMBLE_LEN - 2);
  localparam logic [CW-1:0] PRE_CNT      = CW'(PREAMBLE_LEN);
  localparam logic [CW-1:0] MSG_END      = CW'(MSG_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_SEED, S_TRAIN, S_SELECT, S_RESEED, S_DECRYPT, S_FIN
  } state_e;

  function automatic logic [W-1:0] tap_of(input int unsigned j);
    return TAPS[j*W +: W];
  endfunction

  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s, input logic [W-1:0] t);
    return {s[W-2:0], ^(s & t)};
  endfunction

  state_e                    state_q, state_d;
  logic                      strip_q, strip_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [NTAPS-1:0]          mask_q, mask_d;
  logic [NTAPS-1:0][W-1:0]   lfsr_q, lfsr_d;
  logic [AW-1:0]             raddr_q, raddr_d;
  logic [AW-1:0]             waddr_q, waddr_d;
  logic [7:0]                wdata_q, wdata_d;
  logic                      wr_en_q, wr_en_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic [SW-1:0]             tap_sel_q, tap_sel_d;

  logic [SW-1:0]             sel_idx;
  logic [W-1:0]              sym;
  logic [W-1:0]              key;
  logic [W-1:0]              nxt;

  // Lowest-index surviving candidate wins.
  always_comb begin
    sel_idx = '0;
    for (int j = int'(NTAPS) - 1; j >= 0; j--) begin
      if (mask_q[j]) sel_idx = SW'(j);
    end
  end

  always_comb begin
    state_d   = state_q;
    strip_d   = strip_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    lfsr_d    = lfsr_q;
    raddr_d   = raddr_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wr_en_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    tap_sel_d = tap_sel_q;
    sym       = rdata[W-1:0] ^ PRE_MASK;
    key       = lfsr_q[tap_sel_q];
    nxt       = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          strip_d   = strip;
          raddr_d   = SRC_A;
          mask_d    = '1;
          cnt_d     = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
          tap_sel_d = '0;
          state_d   = S_SEED;
        end
      end

      S_SEED: begin
        raddr_d = SRC_A + AW'(1);
        cnt_d   = '0;
        state_d = S_TRAIN;
      end

      // rdata holds c[cnt]; every candidate must reproduce each preamble symbol.
      S_TRAIN: begin
        for (int unsigned j = 0; j < NTAPS; j++) begin
          if (cnt_q == '0) begin
            lfsr_d[j] = sym;
          end else begin
            nxt       = lfsr_step(lfsr_q[j], tap_of(j));
            lfsr_d[j] = nxt;
            if (nxt != sym) mask_d[j] = 1'b0;
          end
        end
        raddr_d = (cnt_q >= PRE_NEARLAST) ? SRC_A : raddr_q + AW'(1);
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == PRE_LAST) state_d = S_SELECT;
      end

      S_SELECT: begin
        if (mask_q == '0) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_FIN;
        end else begin
          tap_sel_d = sel_idx;
          raddr_d   = SRC_A + AW'(1);
          state_d   = S_RESEED;
        end
      end

      // c[0] is back on rdata; symbol 0 is emitted here and the key advances.
      S_RESEED: begin
        lfsr_d[tap_sel_q] = lfsr_step(sym, tap_of(32'(tap_sel_q)));
        wdata_d           = rdata ^ 8'(sym);
        wr_en_d           = !strip_q;
        waddr_d           = DST_A;
        raddr_d           = raddr_q + AW'(1);
        cnt_d             = CW'(1);
        state_d           = S_DECRYPT;
      end

      S_DECRYPT: begin
        if (cnt_q != MSG_END) begin
          lfsr_d[tap_sel_q] = lfsr_step(key, tap_of(32'(tap_sel_q)));
          wdata_d           = rdata ^ 8'(key);
          if (!strip_q) begin
            wr_en_d = 1'b1;
            waddr_d = DST_A + AW'(cnt_q);
          end else if (cnt_q >= PRE_CNT) begin
            wr_en_d = 1'b1;
            waddr_d = DST_A + AW'(cnt_q) - AW'(PREAMBLE_LEN);
          end
          if (32'(cnt_q) + 32'd3 <= MSG_LEN) raddr_d = raddr_q + AW'(1);
          cnt_d = cnt_q + CW'(1);
        end else begin
          // Drain cycle: the final write is on the bus now.
          raddr_d = SRC_A;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_FIN;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q   <= S_IDLE;
      strip_q   <= 1'b0;
      cnt_q     <= '0;
      mask_q    <= '1;
      lfsr_q    <= '0;
      raddr_q   <= SRC_A;
      waddr_q   <= DST_A;
      wdata_q   <= '0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      tap_sel_q <= '0;
    end else begin
      state_q   <= state_d;
      strip_q   <= strip_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      lfsr_q    <= lfsr_d;
      raddr_q   <= raddr_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      tap_sel_q <= tap_sel_d;
    end
  end

  assign raddr   = raddr_q;
  assign waddr   = waddr_q;
  assign wdata   = wdata_q;
  assign wr_en   = wr_en_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign tap_sel = tap_sel_q;

endmodule

// File: tb/tb_lfsr_decrypt_engine.sv
// Scoreboard bench for lfsr_decrypt_engine: expected writes and results are queued
// at stimulus time and popped by monitors when the DUT writes or raises done.
module tb_lfsr_decrypt_engine;

  localparam int P   = 7;
  localparam int M   = 64;
  localparam int SRC = 64;
  localparam int DST = 0;
  localparam logic [5:0] TAPS_TB [6] = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};
  localparam logic [5:0] SEEDS   [3] = '{6'h01, 6'h2A, 6'h3F};

  logic       clk;
  logic       init_n;
  logic       start;
  logic       strip;
  logic [7:0] raddr;
  logic [7:0] rdata;
  logic [7:0] waddr;
  logic [7:0] wdata;
  logic       wr_en;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] tap_sel;

  lfsr_decrypt_engine dut (
    .clk    (clk),
    .init_n (init_n),
    .start  (start),
    .strip  (strip),
    .raddr  (raddr),
    .rdata  (rdata),
    .waddr  (waddr),
    .wdata  (wdata),
    .wr_en  (wr_en),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .tap_sel(tap_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem   [256];
  logic [7:0] plain [64];
  logic [7:0] ct    [64];

  // Synchronous-read memory: data for raddr appears the following cycle.
  always @(posedge clk) begin
    rdata <= mem[raddr];
    if (wr_en) mem[waddr] <= wdata;
  end

  typedef struct packed { logic [7:0] addr; logic [7:0] data; } wr_t;
  typedef struct packed { logic err; logic [2:0] tap; } res_t;

  wr_t  wr_q [$];
  res_t res_q [$];
  wr_t  mon_w;
  res_t mon_r;
  int   n_checks = 0;
  int   n_errors = 0;
  int   wr_cnt   = 0;
  logic done_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] step6(input logic [5:0] s, input logic [5:0] t);
    return {s[4:0], ^(s & t)};
  endfunction

  // Write monitor.
  always @(negedge clk) begin
    if (init_n && wr_en) begin
      wr_cnt++;
      if (wr_q.size() == 0) begin
        chk("unexpected_write", int'(waddr), -1);
      end else begin
        mon_w = wr_q.pop_front();
        chk("waddr", int'(waddr), int'(mon_w.addr));
        chk("wdata", int'(wdata), int'(mon_w.data));
      end
    end
  end

  // Result monitor on each rising edge of done.
  always @(negedge clk) begin
    if (init_n && done && !done_prev) begin
      if (res_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_r = res_q.pop_front();
        chk("err", int'(err), int'(mon_r.err));
        if (!mon_r.err) chk("tap_sel", int'(tap_sel), int'(mon_r.tap));
      end
    end
    done_prev = done;
  end

  task automatic build_plain();
    string s;
    s = "_______Mr. Watson, come here";
    for (int i = 0; i < M; i++) plain[i] = (i < s.len()) ? s[i] : 8'h20;
  endtask

  // Encrypt plain with tap t from seed; optionally flip bit 0 of c[bad]; fill dst with 0xEE.
  task automatic load_block(input int t, input logic [5:0] seed, input int bad);
    logic [5:0] k;
    k = seed;
    for (int i = 0; i < M; i++) begin
      ct[i] = plain[i] ^ {2'b00, k};
      if (i == bad) ct[i] = ct[i] ^ 8'h01;
      k = step6(k, TAPS_TB[t]);
      mem[SRC + i] <= ct[i];
      mem[DST + i] <= 8'hEE;
    end
  endtask

  task automatic push_expect(input bit s, input int sel, input bit e);
    res_t       r;
    wr_t        w;
    logic [5:0] k;
    r.err = e;
    r.tap = 3'(sel);
    res_q.push_back(r);
    if (!e) begin
      k = ct[0][5:0] ^ 6'h1F;
      for (int i = 0; i < M; i++) begin
        w.data = ct[i] ^ {2'b00, k};
        if (!s) begin
          w.addr = 8'(DST + i);
          wr_q.push_back(w);
        end else if (i >= P) begin
          w.addr = 8'(DST + i - P);
          wr_q.push_back(w);
        end
        k = step6(k, TAPS_TB[sel]);
      end
    end
  endtask

  function automatic int lowest_match(input logic [5:0] seed, input int t);
    logic [5:0] kj;
    logic [5:0] kt;
    bit         alive;
    for (int j = 0; j < 6; j++) begin
      kj = seed;
      kt = seed;
      alive = 1'b1;
      for (int i = 1; i < P; i++) begin
        kj = step6(kj, TAPS_TB[j]);
        kt = step6(kt, TAPS_TB[t]);
        if (kj != kt) alive = 1'b0;
      end
      if (alive) return j;
    end
    return t;
  endfunction

  task automatic start_block(input bit s);
    @(negedge clk);
    start = 1'b1;
    strip = s;
    @(negedge clk);
    start = 1'b0;
    strip = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  function automatic int count_plain_bad(input int from, input int len, input int dst);
    int bad;
    bad = 0;
    for (int i = 0; i < len; i++) if (mem[dst + i] != plain[from + i]) bad++;
    return bad;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit ok;
    int w0;
    int bad;
    int es;

    init_n = 1'b0;
    start  = 1'b0;
    strip  = 1'b0;
    build_plain();
    for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    repeat (3) @(negedge clk);

    chk("rst_raddr",   int'(raddr),   SRC);
    chk("rst_waddr",   int'(waddr),   DST);
    chk("rst_wr_en",   int'(wr_en),   0);
    chk("rst_busy",    int'(busy),    0);
    chk("rst_done",    int'(done),    0);
    chk("rst_err",     int'(err),     0);
    chk("rst_tap_sel", int'(tap_sel), 0);
    init_n = 1'b1;

    // Watson message, tap 3, seed 01, no strip.
    load_block(3, 6'h01, -1);
    push_expect(1'b0, 3, 1'b0);
    w0 = wr_cnt;
    start_block(1'b0);
    chk("t1_busy", int'(busy), 1);
    wait_done(200, lat, ok);
    chk("t1_done_seen", int'(ok), 1);
    chk("t1_latency_bound", (lat <= P + M + 8) ? 1 : 0, 1);
    chk("t1_write_count", wr_cnt - w0, 64);
    chk("t1_busy_low_at_done", int'(busy), 0);
    chk("t1_mem_plain_bad", count_plain_bad(0, 64, DST), 0);

    // Same data with preamble stripped.
    load_block(3, 6'h01, -1);
    push_expect(1'b1, 3, 1'b0);
    w0 = wr_cnt;
    start_block(1'b1);
    wait_done(200, lat, ok);
    chk("t2_done_seen", int'(ok), 1);
    chk("t2_write_count", wr_cnt - w0, 57);
    chk("t2_mem_plain_bad", count_plain_bad(7, 57, DST), 0);
    bad = 0;
    for (int i = 57; i < 64; i++) if (mem[DST + i] != 8'hEE) bad++;
    chk("t2_tail_untouched_bad", bad, 0);

    // Sweep every tap pattern with three seeds.
    for (int t = 0; t < 6; t++) begin
      for (int si = 0; si < 3; si++) begin
        es = lowest_match(SEEDS[si], t);
        load_block(t, SEEDS[si], -1);
        push_expect(1'b0, es, 1'b0);
        w0 = wr_cnt;
        start_block(1'b0);
        wait_done(200, lat, ok);
        chk("sweep_done_seen", int'(ok), 1);
        chk("sweep_write_count", wr_cnt - w0, 64);
      end
    end

    // Corrupted preamble symbol: no survivor.
    load_block(3, 6'h01, 5);
    push_expect(1'b0, 3, 1'b1);
    w0 = wr_cnt;
    start_block(1'b0);
    wait_done(50, lat, ok);
    chk("t4_done_seen", int'(ok), 1);
    chk("t4_latency_bound", (lat <= P + 5) ? 1 : 0, 1);
    chk("t4_err_level", int'(err), 1);
    chk("t4_write_count", wr_cnt - w0, 0);

    // Asynchronous reset in the middle of DECRYPT.
    load_block(3, 6'h01, -1);
    push_expect(1'b0, 3, 1'b0);
    w0 = wr_cnt;
    start_block(1'b0);
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      if (wr_cnt - w0 >= 20) break;
    end
    chk("t5_reached_20_writes", (wr_cnt - w0 >= 20) ? 1 : 0, 1);
    #2;
    init_n = 1'b0;
    #1;
    chk("t5_wr_en_async", int'(wr_en), 0);
    chk("t5_busy_async",  int'(busy),  0);
    chk("t5_done_async",  int'(done),  0);
    chk("t5_raddr_async", int'(raddr), SRC);
    wr_q.delete();
    res_q.delete();
    repeat (2) @(negedge clk);
    init_n = 1'b1;
    load_block(3, 6'h01, -1);
    push_expect(1'b0, 3, 1'b0);
    w0 = wr_cnt;
    start_block(1'b0);
    wait_done(200, lat, ok);
    chk("t5_done_seen", int'(ok), 1);
    chk("t5_write_count", wr_cnt - w0, 64);
    chk("t5_mem_plain_bad", count_plain_bad(0, 64, DST), 0);

    // Start pulsed mid-run is ignored.
    load_block(3, 6'h01, -1);
    push_expect(1'b0, 3, 1'b0);
    w0 = wr_cnt;
    start_block(1'b0);
    repeat (30) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(200, lat, ok);
    chk("t6_done_seen", int'(ok), 1);
    chk("t6_write_count", wr_cnt - w0, 64);

    // Start on a done cycle while IDLE begins a new block.
    load_block(3, 6'h01, -1);
    push_expect(1'b1, 3, 1'b0);
    @(negedge clk);
    chk("t6_done_held_idle", int'(done), 1);
    w0 = wr_cnt;
    start = 1'b1;
    strip = 1'b1;
    @(negedge clk);
    start = 1'b0;
    strip = 1'b0;
    chk("t6_done_cleared", int'(done), 0);
    chk("t6_busy_set", int'(busy), 1);
    wait_done(200, lat, ok);
    chk("t6b_done_seen", int'(ok), 1);
    chk("t6b_write_count", wr_cnt - w0, 57);
    chk("t6b_mem_plain_bad", count_plain_bad(7, 57, DST), 0);

    repeat (3) @(negedge clk);
    chk("wr_queue_drained", wr_q.size(), 0);
    chk("res_queue_drained", res_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
